// File: rtl/lb_pkg.sv
// Shared definitions for the two-master local-bus arbiter.
package lb_pkg;

   localparam int unsigned LB_AW = 32;
   localparam int unsigned LB_DW = 32;

   // Read data handed back when a read is abandoned.
   localparam logic [LB_DW-1:0] TO_DATA_DEF = 32'hDEADBEEF;

   // Arbiter FSM encoding.
   localparam logic [1:0] StIdle   = 2'd0;
   localparam logic [1:0] StIssue  = 2'd1;
   localparam logic [1:0] StWaitRd = 2'd2;
   localparam logic [1:0] StDone   = 2'd3;

   // One captured master command.
   typedef struct packed {
      logic             wr;
      logic [LB_AW-1:0] addr;
      logic [LB_DW-1:0] wr_d;
   } lb_cmd_t;

   // Round-robin pick between two masters; prio names the winner when both are pending.
   function automatic logic rr_pick(input logic pend0, input logic pend1, input logic prio);
      return (pend0 && pend1) ? prio : pend1;
   endfunction

endpackage

// File: rtl/lb_req_hold.sv
// Per-master holding register: captures one command and keeps it pending until the
// arbiter retires it. Strobes arriving while pending are dropped.
module lb_req_hold
   import lb_pkg::*;
(
   input  logic             clk_lb,
   input  logic             reset,
   input  logic             req,
   input  logic             wr,
   input  logic [LB_AW-1:0] addr,
   input  logic [LB_DW-1:0] wr_d,
   input  logic             clr,
   output logic             pending,
   output logic             cmd_wr,
   output logic [LB_AW-1:0] cmd_addr,
   output logic [LB_DW-1:0] cmd_wr_d
);

   logic    pend_q;
   lb_cmd_t cmd_q;

   // Accept a strobe only while idle; the arbiter's clear retires the command.
   always_ff @(posedge clk_lb) begin
      if (reset) begin
         pend_q <= 1'b0;
         cmd_q  <= '0;
      end else if (!pend_q) begin
         if (req) begin
            pend_q <= 1'b1;
            cmd_q  <= '{wr: wr, addr: addr, wr_d: wr_d};
         end
      end else if (clr) begin
         pend_q <= 1'b0;
      end
   end

   assign pending  = pend_q;
   assign cmd_wr   = cmd_q.wr;
   assign cmd_addr = cmd_q.addr;
   assign cmd_wr_d = cmd_q.wr_d;

endmodule

// File: rtl/lb_arb.sv
// Two-master local-bus arbiter. Round-robin grant, one bus transaction at a time,
// read timeout with substitute data. Every output comes straight from a flop.
module lb_arb
   import lb_pkg::*;
#(
   parameter int unsigned      TIMEOUT_CYC = 255,
   parameter logic [LB_DW-1:0] TO_DATA     = TO_DATA_DEF
) (
   input  logic             clk_lb,
   input  logic             reset,

   input  logic             m0_req,
   input  logic             m0_wr,
   input  logic [LB_AW-1:0] m0_addr,
   input  logic [LB_DW-1:0] m0_wr_d,
   output logic             m0_busy,
   output logic             m0_ack,
   output logic [LB_DW-1:0] m0_rd_d,

   input  logic             m1_req,
   input  logic             m1_wr,
   input  logic [LB_AW-1:0] m1_addr,
   input  logic [LB_DW-1:0] m1_wr_d,
   output logic             m1_busy,
   output logic             m1_ack,
   output logic [LB_DW-1:0] m1_rd_d,

   output logic             lb_wr,
   output logic             lb_rd,
   output logic [LB_AW-1:0] lb_addr,
   output logic [LB_DW-1:0] lb_wr_d,
   input  logic [LB_DW-1:0] lb_rd_d,
   input  logic             lb_rd_rdy,
   output logic             lb_timeout
);

   // Last counter value in WAIT_RD before the read is abandoned.
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);

   // Holding registers
   logic             pend0, pend1;
   logic             h0_wr, h1_wr;
   logic [LB_AW-1:0] h0_addr, h1_addr;
   logic [LB_DW-1:0] h0_wr_d, h1_wr_d;
   logic             clr0, clr1;
   lb_cmd_t          cmd0, cmd1;

   // FSM and datapath state
   logic [1:0]       state_q, state_d;
   logic             gnt_q, gnt_d;
   logic             prio_q, prio_d;
   logic             is_wr_q, is_wr_d;
   logic [15:0]      cnt_q, cnt_d;
   logic [LB_AW-1:0] lb_addr_q, lb_addr_d;
   logic [LB_DW-1:0] lb_wr_d_q, lb_wr_d_d;
   logic             wr_stb_q, wr_stb_d;
   logic             rd_stb_q, rd_stb_d;
   logic             timeout_q, timeout_d;
   logic [1:0]       ack_q, ack_d;
   logic [LB_DW-1:0] m0_rd_d_q, m0_rd_d_d;
   logic [LB_DW-1:0] m1_rd_d_q, m1_rd_d_d;

   logic             grant;
   lb_cmd_t          sel;
   logic [LB_DW-1:0] rd_val;

   // The granted master's command is retired in DONE, alongside its ack pulse.
   assign clr0 = (state_q == StDone) && !gnt_q;
   assign clr1 = (state_q == StDone) &&  gnt_q;

   lb_req_hold u_hold0 (
      .clk_lb   (clk_lb),
      .reset    (reset),
      .req      (m0_req),
      .wr       (m0_wr),
      .addr     (m0_addr),
      .wr_d     (m0_wr_d),
      .clr      (clr0),
      .pending  (pend0),
      .cmd_wr   (h0_wr),
      .cmd_addr (h0_addr),
      .cmd_wr_d (h0_wr_d)
   );

   lb_req_hold u_hold1 (
      .clk_lb   (clk_lb),
      .reset    (reset),
      .req      (m1_req),
      .wr       (m1_wr),
      .addr     (m1_addr),
      .wr_d     (m1_wr_d),
      .clr      (clr1),
      .pending  (pend1),
      .cmd_wr   (h1_wr),
      .cmd_addr (h1_addr),
      .cmd_wr_d (h1_wr_d)
   );

   assign cmd0 = '{wr: h0_wr, addr: h0_addr, wr_d: h0_wr_d};
   assign cmd1 = '{wr: h1_wr, addr: h1_addr, wr_d: h1_wr_d};

   // Next-state logic: strobes, acks and read data are computed one cycle early so that
   // they leave the block straight from flops.
   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      prio_d    = prio_q;
      is_wr_d   = is_wr_q;
      cnt_d     = cnt_q;
      lb_addr_d = lb_addr_q;
      lb_wr_d_d = lb_wr_d_q;
      wr_stb_d  = 1'b0;
      rd_stb_d  = 1'b0;
      timeout_d = 1'b0;
      ack_d     = 2'b00;
      rd_val    = '0;
      grant     = rr_pick(pend0, pend1, prio_q);
      sel       = grant ? cmd1 : cmd0;

      case (state_q)
         StIdle: begin
            if (pend0 || pend1) begin
               gnt_d     = grant;
               prio_d    = ~grant;
               is_wr_d   = sel.wr;
               lb_addr_d = sel.addr;
               lb_wr_d_d = sel.wr_d;
               wr_stb_d  = sel.wr;
               rd_stb_d  = ~sel.wr;
               state_d   = StIssue;
            end
         end
         StIssue: begin
            if (is_wr_q) begin
               ack_d[gnt_q] = 1'b1;
               state_d      = StDone;
            end else begin
               cnt_d   = '0;
               state_d = StWaitRd;
            end
         end
         StWaitRd: begin
            // Data arriving on the last allowed cycle still wins over the timeout.
            if (lb_rd_rdy) begin
               ack_d[gnt_q] = 1'b1;
               rd_val       = lb_rd_d;
               state_d      = StDone;
            end else if (cnt_q == TO_LAST) begin
               ack_d[gnt_q] = 1'b1;
               rd_val       = TO_DATA;
               timeout_d    = 1'b1;
               state_d      = StDone;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      m0_rd_d_d = ack_d[0] ? rd_val : '0;
      m1_rd_d_d = ack_d[1] ? rd_val : '0;
   end

   // State and output registers; reset aborts any transaction in flight.
   always_ff @(posedge clk_lb) begin
      if (reset) begin
         state_q   <= StIdle;
         gnt_q     <= 1'b0;
         prio_q    <= 1'b0;
         is_wr_q   <= 1'b0;
         cnt_q     <= '0;
         lb_addr_q <= '0;
         lb_wr_d_q <= '0;
         wr_stb_q  <= 1'b0;
         rd_stb_q  <= 1'b0;
         timeout_q <= 1'b0;
         ack_q     <= 2'b00;
         m0_rd_d_q <= '0;
         m1_rd_d_q <= '0;
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         prio_q    <= prio_d;
         is_wr_q   <= is_wr_d;
         cnt_q     <= cnt_d;
         lb_addr_q <= lb_addr_d;
         lb_wr_d_q <= lb_wr_d_d;
         wr_stb_q  <= wr_stb_d;
         rd_stb_q  <= rd_stb_d;
         timeout_q <= timeout_d;
         ack_q     <= ack_d;
         m0_rd_d_q <= m0_rd_d_d;
         m1_rd_d_q <= m1_rd_d_d;
      end
   end

   assign m0_busy    = pend0;
   assign m1_busy    = pend1;
   assign m0_ack     = ack_q[0];
   assign m1_ack     = ack_q[1];
   assign m0_rd_d    = m0_rd_d_q;
   assign m1_rd_d    = m1_rd_d_q;
   assign lb_wr      = wr_stb_q;
   assign lb_rd      = rd_stb_q;
   assign lb_addr    = lb_addr_q;
   assign lb_wr_d    = lb_wr_d_q;
   assign lb_timeout = timeout_q;

endmodule

// File: tb/tb_lb_arb.sv
// Bench for lb_arb: directed scenarios plus random rounds checked against a
// transaction-level timeline model built from the latency and round-robin rules.
module tb_lb_arb;

   localparam int TO = 4;

   logic        clk_lb = 1'b0;
   logic        reset;
   logic        m0_req, m0_wr, m1_req, m1_wr;
   logic [31:0] m0_addr, m0_wr_d, m1_addr, m1_wr_d;
   logic        m0_busy, m1_busy, m0_ack, m1_ack;
   logic [31:0] m0_rd_d, m1_rd_d;
   logic        lb_wr, lb_rd, lb_rd_rdy, lb_timeout;
   logic [31:0] lb_addr, lb_wr_d, lb_rd_d;

   int n_vec = 0;
   int n_err = 0;
   int prio  = 0;  // model: master that wins the next tie

   always #5 clk_lb = ~clk_lb;

   lb_arb #(
      .TIMEOUT_CYC (TO),
      .TO_DATA     (32'hDEADBEEF)
   ) dut (
      .clk_lb     (clk_lb),
      .reset      (reset),
      .m0_req     (m0_req),
      .m0_wr      (m0_wr),
      .m0_addr    (m0_addr),
      .m0_wr_d    (m0_wr_d),
      .m0_busy    (m0_busy),
      .m0_ack     (m0_ack),
      .m0_rd_d    (m0_rd_d),
      .m1_req     (m1_req),
      .m1_wr      (m1_wr),
      .m1_addr    (m1_addr),
      .m1_wr_d    (m1_wr_d),
      .m1_busy    (m1_busy),
      .m1_ack     (m1_ack),
      .m1_rd_d    (m1_rd_d),
      .lb_wr      (lb_wr),
      .lb_rd      (lb_rd),
      .lb_addr    (lb_addr),
      .lb_wr_d    (lb_wr_d),
      .lb_rd_d    (lb_rd_d),
      .lb_rd_rdy  (lb_rd_rdy),
      .lb_timeout (lb_timeout)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk_lb);
   endtask

   task automatic idle_inputs();
      m0_req = 1'b0; m0_wr = 1'b0; m0_addr = '0; m0_wr_d = '0;
      m1_req = 1'b0; m1_wr = 1'b0; m1_addr = '0; m1_wr_d = '0;
      lb_rd_rdy = 1'b0; lb_rd_d = '0;
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_m0_busy"}, m0_busy, 0);
      chk({tag, "_m1_busy"}, m1_busy, 0);
      chk({tag, "_m0_ack"}, m0_ack, 0);
      chk({tag, "_m1_ack"}, m1_ack, 0);
      chk({tag, "_m0_rd_d"}, m0_rd_d, 0);
      chk({tag, "_m1_rd_d"}, m1_rd_d, 0);
      chk({tag, "_lb_wr"}, lb_wr, 0);
      chk({tag, "_lb_rd"}, lb_rd, 0);
      chk({tag, "_lb_addr"}, lb_addr, 0);
      chk({tag, "_lb_wr_d"}, lb_wr_d, 0);
      chk({tag, "_lb_timeout"}, lb_timeout, 0);
   endtask

   // One round: requests strobed in the current cycle (cycle 0). The model lays out the
   // grant order and, per granted master, the bus-strobe cycle and the ack cycle:
   //   strobe = 2 cycles after the strobe (first) or 2 after the previous ack;
   //   write ack = strobe+1; read ack = strobe+dly+1 if dly<=TO else strobe+TO+1.
   // dly: cycles from lb_rd to lb_rd_rdy. noise: spurious rdy on the strobe cycle.
   // dup: repeat the strobes with other contents while busy.
   task automatic round(input bit r0, input bit r1, input bit w0, input bit w1,
                        input logic [31:0] a0, input logic [31:0] d0,
                        input logic [31:0] a1, input logic [31:0] d1,
                        input int dl0, input int dl1,
                        input logic [31:0] q0, input logic [31:0] q1,
                        input bit noise, input bit dup);
      bit          rq[2], w[2], to[2];
      logic [31:0] ad[2], wd[2], q[2], er[2];
      int          dl[2], sc[2], ac[2];
      int          order[$];
      int          s, g, endc;
      logic        e_wr, e_rd, e_to;
      rq = '{r0, r1}; w = '{w0, w1}; ad = '{a0, a1}; wd = '{d0, d1};
      q = '{q0, q1}; dl = '{dl0, dl1};
      sc = '{-100, -100}; ac = '{-100, -100}; to = '{1'b0, 1'b0}; er = '{32'h0, 32'h0};
      if (r0 && r1) order = '{prio, 1 - prio};
      else if (r0)  order = '{0};
      else          order = '{1};
      s = 2;
      foreach (order[k]) begin
         g = order[k];
         sc[g] = s;
         if (w[g]) begin
            ac[g] = s + 1;
            er[g] = 32'h0;
         end else if (dl[g] <= TO) begin
            ac[g] = s + dl[g] + 1;
            er[g] = q[g];
         end else begin
            ac[g] = s + TO + 1;
            er[g] = 32'hDEADBEEF;
            to[g] = 1'b1;
         end
         s = ac[g] + 2;
      end
      endc = s - 1;
      prio = 1 - order[order.size() - 1];

      m0_req = r0; m0_wr = w0; m0_addr = a0; m0_wr_d = d0;
      m1_req = r1; m1_wr = w1; m1_addr = a1; m1_wr_d = d1;
      for (int c = 1; c <= endc; c++) begin
         tick();
         m0_req = 1'b0; m1_req = 1'b0; lb_rd_rdy = 1'b0; lb_rd_d = '0;
         if (dup && c == 1) begin
            m0_req = r0; m0_wr = ~w0; m0_addr = ~a0; m0_wr_d = ~d0;
            m1_req = r1; m1_wr = ~w1; m1_addr = ~a1; m1_wr_d = ~d1;
         end
         e_wr = 1'b0; e_rd = 1'b0; e_to = 1'b0;
         for (int m = 0; m < 2; m++) begin
            chk(m ? "m1_busy" : "m0_busy", m ? m1_busy : m0_busy, rq[m] && c <= ac[m]);
            chk(m ? "m1_ack" : "m0_ack", m ? m1_ack : m0_ack, rq[m] && c == ac[m]);
            if (rq[m] && c == ac[m]) begin
               chk(m ? "m1_rd_d" : "m0_rd_d", m ? m1_rd_d : m0_rd_d, er[m]);
               e_to = to[m];
            end
            if (rq[m] && c == sc[m]) begin
               e_wr = w[m];
               e_rd = !w[m];
               chk("lb_addr", lb_addr, ad[m]);
               chk("lb_wr_d", lb_wr_d, wd[m]);
            end
            if (rq[m] && noise && c == sc[m]) begin
               lb_rd_rdy = 1'b1; lb_rd_d = 32'hBAD0BAD0;
            end
            if (rq[m] && !w[m] && dl[m] <= TO && c == sc[m] + dl[m]) begin
               lb_rd_rdy = 1'b1; lb_rd_d = q[m];
            end
         end
         chk("lb_wr", lb_wr, e_wr);
         chk("lb_rd", lb_rd, e_rd);
         chk("lb_timeout", lb_timeout, e_to);
      end
   endtask

   initial begin
      bit r0, r1;
      idle_inputs();
      reset = 1'b1;
      tick();
      tick();
      chk_quiet("rst");

      // Strobes coincident with reset are dropped.
      m0_req = 1'b1; m0_wr = 1'b1; m0_addr = 32'h55; m1_req = 1'b1; m1_addr = 32'h66;
      tick();
      reset = 1'b0;
      idle_inputs();
      for (int i = 0; i < 3; i++) begin
         chk_quiet("rst_strobe");
         tick();
      end

      // Single write from m0, then single read from m1 with rdy one cycle after lb_rd.
      round(1, 0, 1, 0, 32'h10, 32'h1, 32'h0, 32'h0, 1, 1, 32'h0, 32'h0, 0, 0);
      round(0, 1, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 1, 1, 32'h0, 32'h11223344, 0, 0);

      // Fresh reset, then two simultaneous pairs: order m0, m1, m0, m1.
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      prio = 0;
      round(1, 1, 1, 0, 32'hA0, 32'h100, 32'hB0, 32'h200, 1, 2, 32'h0, 32'h0BB0BB01, 0, 0);
      round(1, 1, 0, 1, 32'hA4, 32'h104, 32'hB4, 32'h204, 3, 1, 32'h0AA0AA02, 32'h0, 0, 0);

      // Timeout (never rdy), rdy on the last allowed cycle, and one cycle too late.
      round(1, 0, 0, 0, 32'hC0, 32'h0, 32'h0, 32'h0, TO + 2, 1, 32'h0, 32'h0, 0, 0);
      round(0, 1, 0, 0, 32'h0, 32'h0, 32'hC4, 32'h0, 1, TO, 32'h0, 32'hCAFEF00D, 0, 0);
      round(0, 1, 0, 0, 32'h0, 32'h0, 32'hC8, 32'h0, 1, TO + 1, 32'h0, 32'h12345678, 0, 0);

      // Reset while waiting for read data; late rdy must not produce an ack.
      m0_req = 1'b1; m0_wr = 1'b0; m0_addr = 32'h40; m0_wr_d = 32'h0;
      tick();
      m0_req = 1'b0;
      tick();
      chk("abort_lb_rd", lb_rd, 1);
      tick();
      reset = 1'b1;
      tick();
      chk_quiet("abort_in_rst");
      reset = 1'b0;
      prio = 0;
      tick();
      lb_rd_rdy = 1'b1; lb_rd_d = 32'h77777777;
      for (int i = 0; i < 6; i++) begin
         tick();
         lb_rd_rdy = 1'b0; lb_rd_d = '0;
         chk_quiet("abort_after");
      end
      round(1, 0, 0, 0, 32'h44, 32'h0, 32'h0, 32'h0, 2, 1, 32'h5A5A5A5A, 32'h0, 0, 0);

      // Strobes while busy are ignored; spurious rdy outside WAIT_RD is ignored.
      round(1, 0, 1, 0, 32'h80, 32'h8, 32'h0, 32'h0, 1, 1, 32'h0, 32'h0, 0, 1);
      round(1, 1, 0, 1, 32'h90, 32'h9, 32'h94, 32'h19, 2, 1, 32'h01020304, 32'h0, 1, 1);

      // Random rounds.
      for (int i = 0; i < 40; i++) begin
         r0 = 1'($urandom_range(0, 1));
         r1 = 1'($urandom_range(0, 1));
         if (!r0 && !r1) r0 = 1'b1;
         round(r0, r1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               $urandom, $urandom, $urandom, $urandom,
               int'($urandom_range(1, TO + 2)), int'($urandom_range(1, TO + 2)),
               $urandom, $urandom,
               $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
